// File: rtl/serial_hex_pkg.sv
// Shared constants and types for the serial hex display front end.
package serial_hex_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    OCIOSO,
    INICIO,
    DADOS,
    PARIDADE,
    PARADA,
    ESPERA_ALTO
  } rx_state_t;

  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_A   = 8'h41;
  localparam logic [7:0] ASCII_a   = 8'h61;
  localparam logic [7:0] ASCII_ESC = 8'h1B;

endpackage

// File: rtl/hexa7seg.sv
// Hex nibble to seven-segment pattern, active-low, bit order {g,f,e,d,c,b,a}.
module hexa7seg (
  input  logic [3:0] hexa,
  output logic [6:0] display
);

  always_comb begin
    display = 7'b1111111;
    case (hexa)
      4'h0: display = 7'b1000000;
      4'h1: display = 7'b1111001;
      4'h2: display = 7'b0100100;
      4'h3: display = 7'b0110000;
      4'h4: display = 7'b0011001;
      4'h5: display = 7'b0010010;
      4'h6: display = 7'b0000010;
      4'h7: display = 7'b1111000;
      4'h8: display = 7'b0000000;
      4'h9: display = 7'b0010000;
      4'hA: display = 7'b0001000;
      4'hB: display = 7'b0000011;
      4'hC: display = 7'b1000110;
      4'hD: display = 7'b0100001;
      4'hE: display = 7'b0000110;
      4'hF: display = 7'b0001110;
      default: display = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/uart_rx_par.sv
// UART receiver with input synchroniser, optional parity check and break handling.
module uart_rx_par
  import serial_hex_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PARITY       = PAR_NONE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] rx_byte,
  output logic       byte_ok,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic sync1_q, sync2_q;
  rx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic par_bad_q, par_bad_d;
  logic rx, tick;

  assign rx      = sync2_q;
  assign tick    = (cnt_q == LAST);
  assign rx_byte = data_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= OCIOSO;
      cnt_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_bad_q <= 1'b0;
    end else begin
      sync1_q   <= serial_in;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      par_bad_q <= par_bad_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    data_d    = data_q;
    par_bad_d = par_bad_q;
    byte_ok   = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      OCIOSO: begin
        cnt_d = '0;
        if (!rx) state_d = INICIO;
      end
      INICIO: begin
        if (cnt_q == HALF) begin
          cnt_d     = '0;
          bit_d     = '0;
          par_bad_d = 1'b0;
          state_d   = rx ? OCIOSO : DADOS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DADOS: begin
        if (tick) begin
          cnt_d  = '0;
          data_d = {rx, data_q[7:1]};
          bit_d  = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = (PARITY != PAR_NONE) ? PARIDADE : PARADA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARIDADE: begin
        if (tick) begin
          cnt_d     = '0;
          par_bad_d = rx ^ (^data_q) ^ (PARITY == PAR_ODD);
          state_d   = PARADA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARADA: begin
        if (tick) begin
          cnt_d = '0;
          if (!rx) begin
            frame_err = 1'b1;
            state_d   = ESPERA_ALTO;
          end else begin
            frame_err = par_bad_q;
            byte_ok   = !par_bad_q;
            state_d   = OCIOSO;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ESPERA_ALTO: begin
        cnt_d = '0;
        if (rx) state_d = OCIOSO;
      end
      default: state_d = OCIOSO;
    endcase
  end

endmodule

// File: rtl/serial_hex_display_n.sv
// Serial hex digit receiver feeding an N-digit scrolling seven-segment display.
module serial_hex_display_n
  import serial_hex_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned PARITY       = PAR_NONE
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  entrada_serial,
  output logic [7*N_DIGITS-1:0] hexa,
  output logic [4*N_DIGITS-1:0] digitos,
  output logic                  pronto,
  output logic                  erro_char,
  output logic                  erro_quadro
);

  logic [7:0] rx_byte;
  logic byte_ok, frame_err;
  logic [3:0] dig_q [N_DIGITS];
  logic [3:0] dig_d [N_DIGITS];
  logic pronto_q, pronto_d, erro_char_q, erro_char_d, erro_quadro_q, erro_quadro_d;
  logic valid;
  logic [3:0] nib;

  uart_rx_par #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .PARITY      (PARITY)
  ) u_rx (
    .clock    (clock),
    .reset    (reset),
    .serial_in(entrada_serial),
    .rx_byte  (rx_byte),
    .byte_ok  (byte_ok),
    .frame_err(frame_err)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      dig_q         <= '{default: '0};
      pronto_q      <= 1'b0;
      erro_char_q   <= 1'b0;
      erro_quadro_q <= 1'b0;
    end else begin
      dig_q         <= dig_d;
      pronto_q      <= pronto_d;
      erro_char_q   <= erro_char_d;
      erro_quadro_q <= erro_quadro_d;
    end
  end

  always_comb begin
    valid = 1'b0;
    nib   = '0;
    if (rx_byte >= ASCII_0 && rx_byte <= 8'h39) begin
      valid = 1'b1;
      nib   = 4'(rx_byte - ASCII_0);
    end else if (rx_byte >= ASCII_A && rx_byte <= 8'h46) begin
      valid = 1'b1;
      nib   = 4'(rx_byte - ASCII_A) + 4'd10;
    end else if (rx_byte >= ASCII_a && rx_byte <= 8'h66) begin
      valid = 1'b1;
      nib   = 4'(rx_byte - ASCII_a) + 4'd10;
    end
  end

  always_comb begin
    dig_d         = dig_q;
    pronto_d      = 1'b0;
    erro_char_d   = 1'b0;
    erro_quadro_d = frame_err;
    if (byte_ok) begin
      if (valid) begin
        // Newest digit enters at index 0; the oldest falls off the top.
        for (int unsigned i = N_DIGITS - 1; i > 0; i--) dig_d[i] = dig_q[i-1];
        dig_d[0] = nib;
        pronto_d = 1'b1;
      end else if (rx_byte == ASCII_ESC) begin
        dig_d = '{default: '0};
      end else begin
        erro_char_d = 1'b1;
      end
    end
  end

  assign pronto      = pronto_q;
  assign erro_char   = erro_char_q;
  assign erro_quadro = erro_quadro_q;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dig
    assign digitos[4*g +: 4] = dig_q[g];
    hexa7seg u_seg (
      .hexa   (dig_q[g]),
      .display(hexa[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_serial_hex_display_n.sv
// Directed bench: instance 0 without parity, instance 1 with even parity.
module tb_serial_hex_display_n;

  localparam int CPB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rx0, rx1;
  logic [27:0] hexa0, hexa1;
  logic [15:0] dig0, dig1;
  logic pr0, ec0, eq0, pr1, ec1, eq1;

  serial_hex_display_n #(.CLKS_PER_BIT(CPB), .N_DIGITS(4), .PARITY(0)) dut0 (
    .clock(clk), .reset(rst0), .entrada_serial(rx0), .hexa(hexa0), .digitos(dig0),
    .pronto(pr0), .erro_char(ec0), .erro_quadro(eq0));

  serial_hex_display_n #(.CLKS_PER_BIT(CPB), .N_DIGITS(4), .PARITY(1)) dut1 (
    .clock(clk), .reset(rst1), .entrada_serial(rx1), .hexa(hexa1), .digitos(dig1),
    .pronto(pr1), .erro_char(ec1), .erro_quadro(eq1));

  int tests = 0;
  int fails = 0;
  int pr_n[2], ec_n[2], eq_n[2], ovl_n[2];
  int p0, c0, q0;

  always @(negedge clk) begin
    if (pr0) pr_n[0]++;
    if (ec0) ec_n[0]++;
    if (eq0) eq_n[0]++;
    if (int'(pr0) + int'(ec0) + int'(eq0) > 1) ovl_n[0]++;
    if (pr1) pr_n[1]++;
    if (ec1) ec_n[1]++;
    if (eq1) eq_n[1]++;
    if (int'(pr1) + int'(ec1) + int'(eq1) > 1) ovl_n[1]++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input logic v);
    if (s == 0) rx0 = v; else rx1 = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send(input int s, input logic [7:0] b, input logic use_par,
                      input logic pbit, input logic stop);
    drive(s, 1'b0);
    for (int i = 0; i < 8; i++) drive(s, b[i]);
    if (use_par) drive(s, pbit);
    drive(s, stop);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic snap(input int s);
    p0 = pr_n[s]; c0 = ec_n[s]; q0 = eq_n[s];
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rx0 = 1'b1; rx1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dig0", 32'(dig0), 32'h0000);
    chk("reset_hexa0", 32'(hexa0), 32'({7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}));
    chk("reset_flags0", 32'({pr0, ec0, eq0}), 32'd0);
    chk("reset_dig1", 32'(dig1), 32'h0000);
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    snap(0);
    send(0, 8'h33, 1'b0, 1'b0, 1'b1);
    send(0, 8'h41, 1'b0, 1'b0, 1'b1);
    send(0, 8'h66, 1'b0, 1'b0, 1'b1);
    chk("t2_pronto", 32'(pr_n[0] - p0), 32'd3);
    chk("t2_dig", 32'(dig0), 32'h03AF);
    chk("t2_hexa", 32'(hexa0), 32'({7'b1000000, 7'b0110000, 7'b0001000, 7'b0001110}));

    for (int i = 1; i <= 5; i++) send(0, 8'(8'h30 + i), 1'b0, 1'b0, 1'b1);
    chk("t3_dig", 32'(dig0), 32'h2345);
    snap(0);
    send(0, 8'h1B, 1'b0, 1'b0, 1'b1);
    chk("t3_esc_dig", 32'(dig0), 32'h0000);
    chk("t3_esc_flags", 32'((pr_n[0] - p0) + (ec_n[0] - c0) + (eq_n[0] - q0)), 32'd0);

    send(0, 8'h31, 1'b0, 1'b0, 1'b1);
    snap(0);
    send(0, 8'h47, 1'b0, 1'b0, 1'b1);
    send(0, 8'h0D, 1'b0, 1'b0, 1'b1);
    chk("t4_erro_char", 32'(ec_n[0] - c0), 32'd2);
    chk("t4_no_pronto", 32'(pr_n[0] - p0), 32'd0);
    chk("t4_dig", 32'(dig0), 32'h0001);

    snap(1);
    send(1, 8'h35, 1'b1, 1'b0, 1'b1);
    chk("t5_pronto", 32'(pr_n[1] - p0), 32'd1);
    chk("t5_dig", 32'(dig1), 32'h0005);
    chk("t5_hexa_d0", 32'(hexa1[6:0]), 32'(7'b0010010));
    snap(1);
    send(1, 8'h35, 1'b1, 1'b1, 1'b1);
    chk("t5_par_err", 32'(eq_n[1] - q0), 32'd1);
    chk("t5_par_dig", 32'(dig1), 32'h0005);
    snap(1);
    send(1, 8'h35, 1'b1, 1'b0, 1'b0);
    repeat (30 * CPB) @(posedge clk);
    #1;
    chk("t5_brk_eq", 32'(eq_n[1] - q0), 32'd1);
    chk("t5_brk_quiet", 32'((pr_n[1] - p0) + (ec_n[1] - c0)), 32'd0);
    rx1 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send(1, 8'h37, 1'b1, 1'b1, 1'b1);
    chk("t5_after_brk_dig", 32'(dig1), 32'h0057);

    snap(0);
    drive(0, 1'b0);
    for (int i = 0; i < 4; i++) drive(0, 1'(8'h39 >> i));
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    rx0 = 1'b1;
    chk("t6_rst_dig", 32'(dig0), 32'h0000);
    repeat (12 * CPB) @(posedge clk);
    #1;
    chk("t6_rst_flags", 32'((pr_n[0] - p0) + (ec_n[0] - c0) + (eq_n[0] - q0)), 32'd0);
    chk("t6_rst_dig_later", 32'(dig0), 32'h0000);
    send(0, 8'h39, 1'b0, 1'b0, 1'b1);
    chk("t6_dig9", 32'(dig0), 32'h0009);

    send(0, 8'h62, 1'b0, 1'b0, 1'b1);
    send(0, 8'h43, 1'b0, 1'b0, 1'b1);
    chk("lower_upper_dig", 32'(dig0), 32'h09BC);
    chk("overlap0", 32'(ovl_n[0]), 32'd0);
    chk("overlap1", 32'(ovl_n[1]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
